alu_cmd_issue: RTL and testbench
================================

ALU_CMD_ISSUE -- requirements
Module: alu_cmd_issue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 cmd_valid  input  1  upstream command present.
REQ-005 cmd_ready  output  1  block can accept a command this cycle.
REQ-006 cmd_a, cmd_b  input  4 each  ALU operands.
REQ-007 cmd_op  input  3  ALU opcode; uses the ALU's 3-bit opcode encoding (000 add … 111 shift right).
REQ-008 alu_en  output  1  enable to the 4-bit ALU; high only while an issued command is held.
REQ-009 alu_a, alu_b  output  4 each  registered operands to the ALU.
REQ-010 alu_opcode  output  3  registered opcode to the ALU.
REQ-011 alu_result  input  5  combinational result returned by the ALU.
REQ-012 res_valid  output  1  captured result present.
REQ-013 res_ready  input  1  downstream accepts the result.
REQ-014 res_data  output  5  captured alu_result.
REQ-015 res_op  output  3  opcode that produced res_data.
REQ-016 res_zero  output  1  res_data[3:0] == 0.
REQ-017 res_msb  output  1  equal to res_data[4]: carry, borrow, or shifted-out bit.

Function
REQ-018 Handshakes: a transfer occurs only on a rising edge where valid and ready are both high.
REQ-019 Command FIFO: 4 entries of {a, b, op}, in-order.
- cmd_ready = (count < 4); it is registered state only and does not depend on same-cycle pops.
REQ-020 Issue stage: registers alu_a, alu_b, alu_opcode and alu_en.
- alu_en = 1 exactly while the issue stage holds a command.
REQ-021 Output stage: holds res_valid, res_data and res_op.
- It can load when (!res_valid || res_ready).
REQ-022 Issue advance: when alu_en && output can load, the output stage captures alu_result and alu_opcode on that edge.
REQ-023 Issue load: when the FIFO is non-empty && (!alu_en || issue advancing), pop the FIFO head into the issue stage on the same edge.
- Otherwise, if advancing, clear alu_en.
REQ-024 A push and a pop in the same cycle SHALL leave count unchanged.
- A push into an empty FIFO is not visible to issue until the next cycle; there is no bypass.
REQ-025 Latency: a command accepted at edge N SHALL reach issue at N+1 and give res_valid at N+2, provided the pipeline is empty and res_ready is high.
REQ-026 Throughput: with res_ready held high, one result per cycle SHALL be sustained.
REQ-027 Backpressure: when res_ready is low and res_valid is high, res_data, res_op and the issue stage SHALL hold unchanged.
- Maximum in-flight commands = 6 (4 FIFO + 1 issue + 1 output).
REQ-028 When alu_en = 0, alu_a, alu_b and alu_opcode SHALL retain their last values; the ALU outputs 0 and that output is never captured.
REQ-029 Result order SHALL equal command acceptance order; no command SHALL be dropped or duplicated.
REQ-030 FIFO pointers are 2-bit and wrap 3→0; count is 3-bit, range 0..4.

Reset
REQ-031 On rst_n low, asynchronously:
- FIFO count and pointers = 0
- alu_en = 0; alu_a = alu_b = 0; alu_opcode = 000
- res_valid = 0; res_data = 0; res_op = 000
- cmd_ready = 1
REQ-032 Reset mid-operation SHALL discard all FIFO, issue and output contents; no stale result appears after rst_n rises.
REQ-033 The first command SHALL be acceptable on the first rising edge after rst_n deasserts.

Verification
REQ-034 Single add: a=7, b=9, op=000, res_ready=1 → res_valid at N+2; res_data=10000, res_zero=1, res_msb=1, res_op=000.
REQ-035 Back-to-back: commands sub(3,5), and(C,A), shl(B,x), shr(B,x) on consecutive cycles → results 11110, 01000, 10110, 00101 on 4 consecutive cycles, in order.
REQ-036 Backpressure: res_ready=0, cmd_valid held high with 7 commands → exactly 6 accepted, cmd_ready=0 afterwards, res_data stable; on res_ready=1 all 6 drain in order and the 7th is then accepted.
REQ-037 Full FIFO with simultaneous pop: count=4, output draining, cmd_valid=1 → no accept that cycle (cmd_ready=0); accepted the next cycle.
REQ-038 Reset mid-stream: assert rst_n=0 with 3 commands in flight → all outputs at reset values immediately; after release, no res_valid until a new command is sent.
REQ-039 Increment/decrement wrap: inc(F) → 10000; dec(0) → 11111 with res_msb=1.

Source files
------------

// File: rtl/alu_cmd_issue_if.sv
// Bus bundle for alu_cmd_issue: command input, ALU drive/return and result output.
// Handshake: a beat moves on a rising clk edge where valid and ready are both high; valid holds with stable payload until taken.
interface alu_cmd_issue_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_op;

    logic       alu_en;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_opcode;
    logic [4:0] alu_result;

    logic       res_valid;
    logic       res_ready;
    logic [4:0] res_data;
    logic [2:0] res_op;
    logic       res_zero;
    logic       res_msb;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, res_ready,
        output cmd_ready, alu_en, alu_a, alu_b, alu_opcode,
               res_valid, res_data, res_op, res_zero, res_msb
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, res_ready,
        input  cmd_ready, alu_en, alu_a, alu_b, alu_opcode,
               res_valid, res_data, res_op, res_zero, res_msb
    );
endinterface

// File: rtl/alu_cmd_issue.sv
// Command issue pipeline for an external 4-bit ALU: 4-deep command FIFO,
// one issue register stage driving the ALU, one result capture stage.
module alu_cmd_issue (
    input  logic              clk,
    input  logic              rst_n,
    alu_cmd_issue_if.slave    io_if
);

    logic [10:0] r_fifo [4];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;

    logic        r_alu_en;
    logic [3:0]  r_alu_a;
    logic [3:0]  r_alu_b;
    logic [2:0]  r_alu_opcode;

    logic        r_res_valid;
    logic [4:0]  r_res_data;
    logic [2:0]  r_res_op;

    logic        w_cmd_ready;
    logic        w_push;
    logic        w_out_load;
    logic        w_advance;
    logic        w_pop;
    logic [10:0] w_head;

    // Ready comes from the registered count only, so a full FIFO refuses even while popping.
    assign w_cmd_ready = (r_count < 3'd4);
    assign w_push      = io_if.cmd_valid && w_cmd_ready;
    assign w_out_load  = !r_res_valid || io_if.res_ready;
    assign w_advance   = r_alu_en && w_out_load;
    assign w_pop       = (r_count != 3'd0) && (!r_alu_en || w_advance);
    assign w_head      = r_fifo[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {io_if.cmd_a, io_if.cmd_b, io_if.cmd_op};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Operands stay put when idle; only alu_en tells the ALU whether they mean anything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_en     <= 1'b0;
            r_alu_a      <= 4'd0;
            r_alu_b      <= 4'd0;
            r_alu_opcode <= 3'd0;
        end else if (w_pop) begin
            r_alu_en     <= 1'b1;
            r_alu_a      <= w_head[10:7];
            r_alu_b      <= w_head[6:3];
            r_alu_opcode <= w_head[2:0];
        end else if (w_advance) begin
            r_alu_en     <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= 5'd0;
            r_res_op    <= 3'd0;
        end else if (w_advance) begin
            r_res_valid <= 1'b1;
            r_res_data  <= io_if.alu_result;
            r_res_op    <= r_alu_opcode;
        end else if (w_out_load) begin
            r_res_valid <= 1'b0;
        end
    end

    assign io_if.cmd_ready  = w_cmd_ready;
    assign io_if.alu_en     = r_alu_en;
    assign io_if.alu_a      = r_alu_a;
    assign io_if.alu_b      = r_alu_b;
    assign io_if.alu_opcode = r_alu_opcode;
    assign io_if.res_valid  = r_res_valid;
    assign io_if.res_data   = r_res_data;
    assign io_if.res_op     = r_res_op;
    assign io_if.res_zero   = (r_res_data[3:0] == 4'd0);
    assign io_if.res_msb    = r_res_data[4];

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed bench for alu_cmd_issue with a behavioural 4-bit ALU and an in-order result scoreboard.
module tb_alu_cmd_issue;

  logic clk;
  logic rst_n;
  alu_cmd_issue_if bus ();

  alu_cmd_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_if (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU: 000 add, 001 sub, 010 and, 011 or, 100 inc, 101 dec, 110 shl, 111 shr
  always_comb begin
    bus.alu_result = 5'd0;
    if (bus.alu_en) begin
      case (bus.alu_opcode)
        3'b000:  bus.alu_result = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        3'b001:  bus.alu_result = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        3'b010:  bus.alu_result = {1'b0, bus.alu_a & bus.alu_b};
        3'b011:  bus.alu_result = {1'b0, bus.alu_a | bus.alu_b};
        3'b100:  bus.alu_result = {1'b0, bus.alu_a} + 5'd1;
        3'b101:  bus.alu_result = {1'b0, bus.alu_a} - 5'd1;
        3'b110:  bus.alu_result = {bus.alu_a, 1'b0};
        default: bus.alu_result = {2'b00, bus.alu_a[3:1]};
      endcase
    end
  end

  int          n_vec;
  int          n_mis;
  logic [7:0]  exp_q[$];
  logic [7:0]  cmd_exp;
  logic [7:0]  mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op, input logic [4:0] res);
    bus.cmd_valid = v;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    cmd_exp       = {op, res};
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  // scoreboard: commands enter the queue on acceptance, results leave it in order
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.cmd_valid && bus.cmd_ready) exp_q.push_back(cmd_exp);
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          chk("res_extra", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("res_data", bus.res_data, mon_e[4:0]);
          chk("res_op", bus.res_op, mon_e[7:5]);
          chk("res_zero", bus.res_zero, (mon_e[3:0] == 4'd0));
          chk("res_msb", bus.res_msb, mon_e[4]);
        end
      end
    end
  end

  // backpressure vectors: a, b, op, hand-computed result
  logic [3:0] bp_a   [7] = '{4'h1, 4'hF, 4'h5, 4'h0, 4'h7, 4'hF, 4'h8};
  logic [3:0] bp_b   [7] = '{4'h2, 4'hF, 4'hA, 4'h1, 4'h0, 4'h3, 4'h0};
  logic [2:0] bp_op  [7] = '{3'd0, 3'd0, 3'd3, 3'd1, 3'd4, 3'd2, 3'd5};
  logic [4:0] bp_res [7] = '{5'b00011, 5'b11110, 5'b01111, 5'b11111,
                             5'b01000, 5'b00011, 5'b00111};

  initial begin
    int   k;
    logic acc;
    n_vec = 0;
    n_mis = 0;
    rst_n = 1'b0;
    bus.res_ready = 1'b1;
    set_cmd(1'b0, 4'd0, 4'd0, 3'd0, 5'd0);

    // reset values
    repeat (3) tick();
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_alu_en", bus.alu_en, 0);
    chk("rst_alu_ab", {bus.alu_a, bus.alu_b, bus.alu_opcode}, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", {bus.res_data, bus.res_op}, 0);

    // single add on the first edge after release, latency N+1 / N+2
    rst_n = 1'b1;
    set_cmd(1'b1, 4'd7, 4'd9, 3'd0, 5'b10000);
    tick();
    set_cmd(1'b0, 4'd0, 4'd0, 3'd0, 5'd0);
    chk("lat_n_alu_en", bus.alu_en, 0);
    tick();
    chk("lat_n1_alu_en", bus.alu_en, 1);
    chk("lat_n1_alu_ab", {bus.alu_a, bus.alu_b}, 8'h79);
    chk("lat_n1_res_valid", bus.res_valid, 0);
    tick();
    chk("lat_n2_res_valid", bus.res_valid, 1);
    chk("lat_n2_res_data", bus.res_data, 5'b10000);
    chk("lat_n2_zero_msb", {bus.res_zero, bus.res_msb}, 2'b11);
    tick();
    chk("idle_res_valid", bus.res_valid, 0);

    // back-to-back: four results on four consecutive cycles
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: set_cmd(1'b1, 4'h3, 4'h5, 3'd1, 5'b11110);
        1: set_cmd(1'b1, 4'hC, 4'hA, 3'd2, 5'b01000);
        2: set_cmd(1'b1, 4'hB, 4'($urandom_range(0, 15)), 3'd6, 5'b10110);
        default: set_cmd(1'b1, 4'hB, 4'($urandom_range(0, 15)), 3'd7, 5'b00101);
      endcase
      tick();
      if (i >= 2) chk("b2b_res_valid", bus.res_valid, 1);
    end
    set_cmd(1'b0, 4'd0, 4'd0, 3'd0, 5'd0);
    tick();
    chk("b2b_res_valid", bus.res_valid, 1);
    tick();
    chk("b2b_res_valid", bus.res_valid, 1);
    tick();
    chk("b2b_done", bus.res_valid, 0);

    // backpressure: seven offered, six accepted
    bus.res_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      if (k < 7) set_cmd(1'b1, bp_a[k], bp_b[k], bp_op[k], bp_res[k]);
      acc = bus.cmd_valid && bus.cmd_ready;
      tick();
      if (acc) k++;
    end
    chk("bp_accepted", k, 6);
    chk("bp_cmd_ready", bus.cmd_ready, 0);
    chk("bp_res_hold", {bus.res_valid, bus.res_data}, 6'b1_00011);
    chk("bp_issue_hold", {bus.alu_en, bus.alu_a, bus.alu_opcode}, 8'b1_1111_000);
    repeat (3) tick();
    chk("bp_res_stable", {bus.res_data, bus.res_op}, 8'b00011_000);
    chk("bp_issue_stable", {bus.alu_a, bus.alu_b}, 8'hFF);

    // full FIFO while the output drains: refused this cycle, taken next
    bus.res_ready = 1'b1;
    chk("full_ready_low", bus.cmd_ready, 0);
    tick();
    chk("full_ready_back", bus.cmd_ready, 1);
    acc = bus.cmd_valid && bus.cmd_ready;
    tick();
    if (acc) k++;
    chk("bp_accepted7", k, 7);
    set_cmd(1'b0, 4'd0, 4'd0, 3'd0, 5'd0);
    drain();

    // increment / decrement wrap
    set_cmd(1'b1, 4'hF, 4'd0, 3'd4, 5'b10000);
    tick();
    set_cmd(1'b1, 4'h0, 4'd0, 3'd5, 5'b11111);
    tick();
    set_cmd(1'b0, 4'd0, 4'd0, 3'd0, 5'd0);
    drain();

    // reset with three commands in flight
    bus.res_ready = 1'b0;
    set_cmd(1'b1, 4'h4, 4'h4, 3'd0, 5'b01000);
    tick();
    set_cmd(1'b1, 4'h6, 4'h1, 3'd1, 5'b00101);
    tick();
    set_cmd(1'b1, 4'h9, 4'h6, 3'd3, 5'b01111);
    tick();
    set_cmd(1'b0, 4'd0, 4'd0, 3'd0, 5'd0);
    chk("pre_rst_busy", {bus.res_valid, bus.alu_en}, 2'b11);
    rst_n = 1'b0;
    #2;
    exp_q.delete();
    chk("mid_rst_res", {bus.res_valid, bus.res_data, bus.res_op}, 0);
    chk("mid_rst_issue", {bus.alu_en, bus.alu_a, bus.alu_b, bus.alu_opcode}, 0);
    chk("mid_rst_ready", bus.cmd_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_no_res", {bus.res_valid, bus.alu_en}, 0);
    end
    set_cmd(1'b1, 4'h2, 4'h3, 3'd0, 5'b00101);
    tick();
    set_cmd(1'b0, 4'd0, 4'd0, 3'd0, 5'd0);
    tick();
    tick();
    chk("post_rst_res", {bus.res_valid, bus.res_data}, 6'b1_00101);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
